// File: rtl/parking_gate_controller.sv
// Parking lot entry/exit barrier controller.
// Two independent FSMs emit the one-cycle occupancy events.
module parking_gate_controller #(
   parameter int OPEN_TIME     = 8,
   parameter int OPEN_TIMEOUT  = 200,
   parameter int REJECT_CYCLES = 4,
   parameter int CLOSE_HOLD    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] hour,
   input  logic       uni_is_vacated_space,
   input  logic       is_vacated_space,
   input  logic       entry_loop,
   input  logic       entry_card_valid,
   input  logic       entry_card_uni,
   input  logic       entry_pass,
   input  logic       exit_loop,
   input  logic       exit_card_valid,
   input  logic       exit_card_uni,
   input  logic       exit_pass,
   output logic       entry_barrier_open,
   output logic       entry_reject,
   output logic       exit_barrier_open,
   output logic       car_entered,
   output logic       is_uni_car_entered,
   output logic       car_exited,
   output logic       is_uni_car_exited
);

   typedef enum logic [2:0] {
      EN_IDLE,
      EN_CHECK,
      EN_REJECT,
      EN_OPEN,
      EN_PASS,
      EN_CLOSE
   } en_state_t;

   typedef enum logic [1:0] {
      EX_IDLE,
      EX_OPEN,
      EX_PASS,
      EX_CLOSE
   } ex_state_t;

   localparam logic [15:0] TO_LAST   = 16'(OPEN_TIMEOUT - 1);
   localparam logic [15:0] REJ_N     = 16'(REJECT_CYCLES);
   localparam logic [15:0] HOLD_LAST = 16'(CLOSE_HOLD - 1);
   localparam logic [4:0]  OPEN_H    = 5'(OPEN_TIME);

   en_state_t   en_state, en_next;
   logic [15:0] en_cnt, en_cnt_d;
   logic        en_uni, en_uni_d;
   logic        admit;
   logic        en_open_d, en_reject_d;
   logic        en_event_d, en_event_uni_d;

   ex_state_t   ex_state, ex_next;
   logic [15:0] ex_cnt, ex_cnt_d;
   logic        ex_uni, ex_uni_d;
   logic        ex_open_d;
   logic        ex_event_d, ex_event_uni_d;

   assign admit = (hour >= OPEN_H) && (hour <= 5'd23) &&
                  (en_uni ? uni_is_vacated_space : is_vacated_space);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_state           <= EN_IDLE;
         en_cnt             <= '0;
         en_uni             <= 1'b0;
         entry_barrier_open <= 1'b0;
         entry_reject       <= 1'b0;
         car_entered        <= 1'b0;
         is_uni_car_entered <= 1'b0;
      end else begin
         en_state           <= en_next;
         en_cnt             <= en_cnt_d;
         en_uni             <= en_uni_d;
         entry_barrier_open <= en_open_d;
         entry_reject       <= en_reject_d;
         car_entered        <= en_event_d;
         is_uni_car_entered <= en_event_uni_d;
      end
   end

   // Open timer runs only once the barrier is actually up.
   always_comb begin
      en_next  = en_state;
      en_cnt_d = en_cnt;
      en_uni_d = en_uni;
      unique case (en_state)
         EN_IDLE: begin
            en_cnt_d = '0;
            if (entry_loop && entry_card_valid) begin
               en_next  = EN_CHECK;
               en_uni_d = entry_card_uni;
            end
         end
         EN_CHECK: begin
            en_cnt_d = '0;
            en_next  = admit ? EN_OPEN : EN_REJECT;
         end
         EN_REJECT: begin
            if (!entry_loop)
               en_next = EN_IDLE;
            else if (en_cnt != REJ_N)
               en_cnt_d = en_cnt + 16'd1;
         end
         EN_OPEN: begin
            if (entry_pass) begin
               en_next = EN_PASS;
            end else if (entry_barrier_open) begin
               if (en_cnt == TO_LAST) begin
                  en_next  = EN_CLOSE;
                  en_cnt_d = '0;
               end else begin
                  en_cnt_d = en_cnt + 16'd1;
               end
            end
         end
         EN_PASS: begin
            if (!entry_pass) begin
               en_next  = EN_CLOSE;
               en_cnt_d = '0;
            end
         end
         EN_CLOSE: begin
            if (en_cnt == HOLD_LAST)
               en_next = EN_IDLE;
            else
               en_cnt_d = en_cnt + 16'd1;
         end
         default: en_next = EN_IDLE;
      endcase
   end

   always_comb begin
      en_open_d = (en_state inside {EN_OPEN, EN_PASS}) &&
                  (en_next inside {EN_OPEN, EN_PASS});
      en_reject_d = (en_state == EN_REJECT) &&
                    (en_next == EN_REJECT) && (en_cnt != REJ_N);
      en_event_d     = (en_state == EN_PASS) && !entry_pass;
      en_event_uni_d = en_event_d && en_uni;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_state          <= EX_IDLE;
         ex_cnt            <= '0;
         ex_uni            <= 1'b0;
         exit_barrier_open <= 1'b0;
         car_exited        <= 1'b0;
         is_uni_car_exited <= 1'b0;
      end else begin
         ex_state          <= ex_next;
         ex_cnt            <= ex_cnt_d;
         ex_uni            <= ex_uni_d;
         exit_barrier_open <= ex_open_d;
         car_exited        <= ex_event_d;
         is_uni_car_exited <= ex_event_uni_d;
      end
   end

   always_comb begin
      ex_next  = ex_state;
      ex_cnt_d = ex_cnt;
      ex_uni_d = ex_uni;
      unique case (ex_state)
         EX_IDLE: begin
            ex_cnt_d = '0;
            if (exit_loop && exit_card_valid) begin
               ex_next  = EX_OPEN;
               ex_uni_d = exit_card_uni;
            end
         end
         EX_OPEN: begin
            if (exit_pass) begin
               ex_next = EX_PASS;
            end else if (exit_barrier_open) begin
               if (ex_cnt == TO_LAST) begin
                  ex_next  = EX_CLOSE;
                  ex_cnt_d = '0;
               end else begin
                  ex_cnt_d = ex_cnt + 16'd1;
               end
            end
         end
         EX_PASS: begin
            if (!exit_pass) begin
               ex_next  = EX_CLOSE;
               ex_cnt_d = '0;
            end
         end
         EX_CLOSE: begin
            if (ex_cnt == HOLD_LAST)
               ex_next = EX_IDLE;
            else
               ex_cnt_d = ex_cnt + 16'd1;
         end
         default: ex_next = EX_IDLE;
      endcase
   end

   always_comb begin
      ex_open_d = (ex_state inside {EX_OPEN, EX_PASS}) &&
                  (ex_next inside {EX_OPEN, EX_PASS});
      ex_event_d     = (ex_state == EX_PASS) && !exit_pass;
      ex_event_uni_d = ex_event_d && ex_uni;
   end

endmodule
